// File: rtl/nn_pkg.sv
// Shared Q2.6 constants, sequencer state encoding and address-width helper
// for the fully-connected layer datapath.
package nn_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 6;
    localparam logic signed [DATA_W-1:0] Q_ONE = 8'sh40;
    localparam logic signed [DATA_W-1:0] Q_MAX = 8'sh7F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUTPUT = 3'd4
    } seq_state_e;

    // Address width for a buffer of 'depth' entries, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Element/neuron counters and weight address generation for mac_sequencer.
// The weight base advances by VEC_LEN per neuron, so no multiplier is needed.
module seq_addr_gen
    import nn_pkg::*;
#(
    parameter int VEC_LEN     = 16,
    parameter int NUM_NEURONS = 4,
    parameter int IN_AW       = addr_w(VEC_LEN),
    parameter int W_AW        = addr_w(VEC_LEN * NUM_NEURONS),
    parameter int N_AW        = addr_w(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pass_start_i,
    input  logic             neuron_next_i,
    input  logic             elem_step_i,
    output logic [IN_AW-1:0] in_addr_o,
    output logic [W_AW-1:0]  w_addr_o,
    output logic [N_AW-1:0]  neuron_o,
    output logic             last_elem_o,
    output logic             last_neuron_o
);

    localparam logic [IN_AW-1:0] ELEM_LAST   = IN_AW'(VEC_LEN - 1);
    localparam logic [N_AW-1:0]  NEURON_LAST = N_AW'(NUM_NEURONS - 1);
    localparam logic [W_AW-1:0]  BASE_STEP   = W_AW'(VEC_LEN);

    logic [IN_AW-1:0] elem_q, elem_d;
    logic [N_AW-1:0]  neuron_q, neuron_d;
    logic [W_AW-1:0]  base_q, base_d;
    logic [W_AW-1:0]  waddr_q, waddr_d;

    // Next-state selection: pass start wins over neuron advance over element step.
    always_comb begin
        elem_d   = elem_q;
        neuron_d = neuron_q;
        base_d   = base_q;
        waddr_d  = waddr_q;
        if (pass_start_i) begin
            elem_d   = '0;
            neuron_d = '0;
            base_d   = '0;
            waddr_d  = '0;
        end else if (neuron_next_i) begin
            elem_d   = '0;
            neuron_d = neuron_q + N_AW'(1'b1);
            base_d   = base_q + BASE_STEP;
            waddr_d  = base_q + BASE_STEP;
        end else if (elem_step_i) begin
            elem_d   = elem_q + IN_AW'(1'b1);
            waddr_d  = waddr_q + W_AW'(1'b1);
        end else begin
            elem_d   = elem_q;
            waddr_d  = waddr_q;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_q   <= '0;
            neuron_q <= '0;
            base_q   <= '0;
            waddr_q  <= '0;
        end else begin
            elem_q   <= elem_d;
            neuron_q <= neuron_d;
            base_q   <= base_d;
            waddr_q  <= waddr_d;
        end
    end

    assign in_addr_o     = elem_q;
    assign w_addr_o      = waddr_q;
    assign neuron_o      = neuron_q;
    assign last_elem_o   = (elem_q == ELEM_LAST);
    assign last_neuron_o = (neuron_q == NEURON_LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM running one external MAC over a fully-connected layer.
// Optional build macro PERF_COUNTER_EN adds the 16-bit stall_count output.
module mac_sequencer
    import nn_pkg::*;
#(
    parameter int VEC_LEN     = 16,
    parameter int NUM_NEURONS = 4,
    parameter int IN_AW       = addr_w(VEC_LEN),
    parameter int W_AW        = addr_w(VEC_LEN * NUM_NEURONS),
    parameter int N_AW        = addr_w(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [W_AW-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              mac_clear,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [N_AW-1:0]   res_index
`ifdef PERF_COUNTER_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    seq_state_e        state_q;
    logic              busy_q, done_q, clear_q, enable_q, valid_q, drain_q;
    logic [DATA_W-1:0] data_q;
    logic [N_AW-1:0]   index_q;

    logic              accept_s, handshake_s, next_neuron_s, step_s;
    logic              last_elem_s, last_neuron_s;
    logic [N_AW-1:0]   neuron_s;

    assign accept_s      = (state_q == ST_IDLE) && start;
    assign handshake_s   = (state_q == ST_OUTPUT) && valid_q && res_ready;
    assign next_neuron_s = handshake_s && !last_neuron_s;
    assign step_s        = (state_q == ST_RUN) && !last_elem_s;

    seq_addr_gen #(
        .VEC_LEN     (VEC_LEN),
        .NUM_NEURONS (NUM_NEURONS),
        .IN_AW       (IN_AW),
        .W_AW        (W_AW),
        .N_AW        (N_AW)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .pass_start_i  (accept_s),
        .neuron_next_i (next_neuron_s),
        .elem_step_i   (step_s),
        .in_addr_o     (in_addr),
        .w_addr_o      (w_addr),
        .neuron_o      (neuron_s),
        .last_elem_o   (last_elem_s),
        .last_neuron_o (last_neuron_s)
    );

    // Sequencer FSM; enable trails RUN by one cycle to meet the buffer read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clear_q  <= 1'b1;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            drain_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            enable_q <= (state_q == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    clear_q <= 1'b1;
                    if (start) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_RUN;
                    clear_q <= 1'b0;
                end
                ST_RUN: begin
                    if (last_elem_s) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                // Second drain cycle sees mac_out after the final enabled accumulate.
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_OUTPUT;
                        drain_q <= 1'b0;
                        data_q  <= mac_out;
                        index_q <= neuron_s;
                        valid_q <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (handshake_s) begin
                        valid_q <= 1'b0;
                        clear_q <= 1'b1;
                        if (last_neuron_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    clear_q <= 1'b1;
                    valid_q <= 1'b0;
                    drain_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_clear  = clear_q;
    assign mac_enable = enable_q;
    assign mac_a      = in_data;
    assign mac_b      = w_data;
    assign res_valid  = valid_q;
    assign res_data   = data_q;
    assign res_index  = index_q;

`ifdef PERF_COUNTER_EN
    logic [15:0] stall_q;

    // Saturating count of cycles a result waits on the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (accept_s) begin
            stall_q <= 16'h0000;
        end else if ((state_q == ST_OUTPUT) && valid_q && !res_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with modelled synchronous buffers and MAC.
module tb_mac_sequencer;
    import nn_pkg::*;

    localparam int VL    = 3;
    localparam int NN    = 2;
    localparam int IN_AW = addr_w(VL);
    localparam int W_AW  = addr_w(VL * NN);
    localparam int N_AW  = addr_w(NN);

    logic              clk = 1'b0;
    logic              reset, start, res_ready;
    logic              busy, done, mac_clear, mac_enable, res_valid;
    logic [IN_AW-1:0]  in_addr;
    logic [W_AW-1:0]   w_addr;
    logic [7:0]        in_data, w_data, mac_a, mac_b, mac_out, res_data;
    logic [N_AW-1:0]   res_index;
`ifdef PERF_COUNTER_EN
    logic [15:0]       stall_count;
`endif

    mac_sequencer #(.VEC_LEN(VL), .NUM_NEURONS(NN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .mac_clear  (mac_clear),
        .mac_enable (mac_enable),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_out    (mac_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_index  (res_index)
`ifdef PERF_COUNTER_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read activation and weight buffers.
    logic [7:0] in_mem [0:3];
    logic [7:0] w_mem  [0:7];
    always_ff @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    // MAC: wide accumulator of truncated Q2.6 products, output clamped to [0,127].
    logic signed [15:0] prod_s;
    logic signed [19:0] prod_ext_s, acc_q;
    assign prod_s     = $signed(mac_a) * $signed(mac_b);
    assign prod_ext_s = prod_s;
    always_ff @(posedge clk) begin
        if (mac_clear)       acc_q <= '0;
        else if (mac_enable) acc_q <= acc_q + (prod_ext_s >>> FRAC_W);
    end
    assign mac_out = (acc_q < 0) ? 8'h00 : ((acc_q > 20'sd127) ? 8'h7F : acc_q[7:0]);

    int checks_cnt = 0;
    int errors_cnt = 0;
    int done_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [7:0] data; int idx; } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input int idx, input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] model(input int n);
        int acc = 0;
        for (int k = 0; k < VL; k++)
            acc += (int'($signed(in_mem[k])) * int'($signed(w_mem[n*VL + k]))) >>> FRAC_W;
        if (acc < 0)        return 8'h00;
        else if (acc > 127) return 8'h7F;
        else                return 8'(acc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        while (!done && n < 200) begin
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 200) chk("done_timeout", done, 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++) in_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) w_mem[i]  = 8'($urandom_range(0, 255));
    endtask

    // Result monitor: pops the scoreboard on each handshake and checks hold stability.
    initial begin
        exp_t            e;
        logic            hold_pend;
        logic [7:0]      hold_d;
        logic [N_AW-1:0] hold_i;
        hold_pend = 1'b0;
        hold_d    = 8'h00;
        hold_i    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (hold_pend && res_valid) begin
                    chk("hold_data", res_data, hold_d);
                    chk("hold_index", res_index, hold_i);
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_result", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", res_data, e.data);
                        chk("res_index", res_index, e.idx);
                    end
                end
                hold_pend = res_valid && !res_ready;
                hold_d    = res_data;
                hold_i    = res_index;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) w_mem[i]  = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_mac_enable", mac_enable, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_index", res_index, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        reset = 1'b0;
        tick();

        // Pass A: dot product 0x2C, latency and throughput with ready held high.
        in_mem[0] = 8'h15; in_mem[1] = 8'h21; in_mem[2] = 8'h10;
        for (int k = 0; k < VL; k++) begin
            w_mem[k]      = 8'h2A;
            w_mem[VL + k] = 8'($urandom_range(0, 255));
        end
        push_exp(0, 8'h2C);
        push_exp(1, model(1));
        res_ready = 1'b1;
        start_pass();
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("first_latency", n, VL + 3);
        tick();
        n = 1;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("throughput", n, VL + 4);
        tick();
        chk("done_pulse", done, 1);
        chk("idle_after_last", busy, 0);
        tick();
        chk("done_width", done, 0);

        // Pass B: negative intermediate sum clamped only at the output.
        for (int k = 0; k < VL; k++) in_mem[k] = 8'h0C;
        w_mem[0] = 8'h02; w_mem[1] = 8'hC0; w_mem[2] = 8'h7F;
        for (int k = 0; k < VL; k++) w_mem[VL + k] = 8'($urandom_range(0, 255));
        push_exp(0, 8'h0B);
        push_exp(1, model(1));
        start_pass();
        wait_done(1'b0);

        // Pass C: saturation with backpressure on neuron 0.
        for (int k = 0; k < VL; k++) in_mem[k] = Q_ONE;
        for (int k = 0; k < VL * NN; k++) w_mem[k] = 8'h30;
        push_exp(0, Q_MAX);
        push_exp(1, Q_MAX);
        res_ready = 1'b0;
        start_pass();
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("bp_valid", res_valid, 1);
        repeat (5) begin
            tick();
            chk("bp_valid_held", res_valid, 1);
            chk("bp_no_clear", mac_clear, 0);
            chk("bp_no_enable", mac_enable, 0);
        end
`ifdef PERF_COUNTER_EN
        chk("stall_count", stall_count, 5);
`endif
        res_ready = 1'b1;
        wait_done(1'b0);
`ifdef PERF_COUNTER_EN
        chk("stall_count_final", stall_count, 5);
`endif

        // Pass D: reset during RUN of neuron 1.
        fill_random();
        push_exp(0, model(0));
        push_exp(1, model(1));
        start_pass();
        repeat (9) tick();
        chk("n1_in_addr", in_addr, 1);
        chk("n1_w_addr", w_addr, VL + 1);
        chk("n1_enable", mac_enable, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mac_clear", mac_clear, 1);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_mac_enable", mac_enable, 0);
        chk("arst_w_addr", w_addr, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();

        // Pass E: fresh pass after reset, start pokes while busy, restart from done.
        fill_random();
        push_exp(0, model(0));
        push_exp(1, model(1));
        start_pass();
        wait_done(1'b1);
        chk("idle_at_done", busy, 0);
        push_exp(0, model(0));
        push_exp(1, model(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_next_edge", busy, 1);
        wait_done(1'b0);
        repeat (10) tick();
        chk("no_spurious_restart", busy, 0);

        chk("done_count", done_cnt, 5);
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Control FSM that runs one mac unit over a fully-connected layer. For each neuron it clears the accumulator, streams VEC_LEN input/weight pairs from synchronous-read buffers, drains the MAC pipeline and presents the result on a valid/ready port. It sits between the activation/weight buffers and the layer output buffer. It does not instantiate the mac; it drives the mac's reset, enable, a and b ports and reads its out port.

Parameters:
VEC_LEN, 16, input vector length (elements per dot product); must be ≥1.
NUM_NEURONS, 4, neurons (dot products) per start.
DATA_W, 8, signed Q2.6 data width; fixed by the mac.
IN_AW, $clog2(VEC_LEN) (min 1), input buffer address width.
W_AW, $clog2(VEC_LEN*NUM_NEURONS) (min 1), weight buffer address width.
N_AW, $clog2(NUM_NEURONS) (min 1), neuron index width.

Ports:
clk  in  1  clock.
reset  in  1  async active-high reset.
start  in  1  start one layer pass; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last result handshake.
in_addr  out  IN_AW  input buffer read address.
in_data  in  DATA_W  input buffer read data; valid 1 cycle after address.
w_addr  out  W_AW  weight buffer read address.
w_data  in  DATA_W  weight buffer read data; valid 1 cycle after address.
mac_clear  out  1  drives mac reset.
mac_enable  out  1  drives mac enable.
mac_a  out  DATA_W  drives mac a; equals in_data.
mac_b  out  DATA_W  drives mac b; equals w_data.
mac_out  in  DATA_W  mac out: clamped to [0,127], updated at the clock edge after an enabled cycle.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_data  out  DATA_W  registered neuron result.
res_index  out  N_AW  neuron number of res_data.

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, mac_enable=0, mac_clear=1, res_valid=0, res_data=0, res_index=0, in_addr=0, w_addr=0, element and neuron counters=0. The MAC is therefore held cleared during reset.
- States: IDLE, CLEAR, RUN, DRAIN, OUTPUT.
- IDLE: mac_clear=1.
  - start=1 → CLEAR, neuron=0.
  - start is ignored in all other states.
- CLEAR: 1 cycle, mac_clear=1, element k=0 → RUN.
- RUN: VEC_LEN cycles.
  - Cycle k issues in_addr=k and w_addr=neuron*VEC_LEN+k.
  - k=VEC_LEN-1 → DRAIN.
- mac_enable is the RUN-state flag delayed by one register stage, so it is aligned with the returning buffer data. mac_a and mac_b are combinational pass-throughs.
- DRAIN: exactly 2 cycles.
  - Cycle 1 holds the last enabled MAC cycle.
  - At the end of cycle 2, res_data<=mac_out, res_index<=neuron, res_valid<=1 → OUTPUT.
- Latency: with E0 = the start-accept edge, the first res_valid rises at edge E(VEC_LEN+3).
- OUTPUT: res_data and res_index stay stable while res_valid=1 and res_ready=0.
  - Handshake (valid&ready at an edge), neuron<NUM_NEURONS-1: res_valid<=0, neuron++ → CLEAR.
  - Handshake on the last neuron: → IDLE with done=1 for exactly one cycle.
- Throughput with res_ready held high: one result every VEC_LEN+4 cycles.
- Boundary cases:
  - VEC_LEN=1: RUN lasts 1 cycle.
  - NUM_NEURONS=1: done follows the first handshake.
  - res_ready=1 before res_valid has no effect.
  - start held high while done pulses does not restart in the same cycle. The new pass begins from IDLE on the next edge.
- Arithmetic: none in this block. Saturation and negative clamping are done by the mac; results are passed through unmodified.

Optional Feature:
PERF_COUNTER_EN:
- Defined: adds output stall_count (16 bits).
  - Reset to 0 and cleared at start accept.
  - Increments each OUTPUT cycle with res_valid=1 and res_ready=0.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package nn_pkg holds:
  - Q2.6 constants: DATA_W=8, FRAC_W=6, Q_ONE=8'sh40, Q_MAX=8'sh7F.
  - The FSM state enum typedef.
- One natural sub-module, seq_addr_gen: element counter, neuron counter, w_addr base accumulation (base += VEC_LEN per neuron, no multiplier), and last-element/last-neuron flags.

Test Plan:
1. VEC_LEN=3, NUM_NEURONS=1; inputs 0x15,0x21,0x10; weights 0x2A,0x2A,0x2A; res_ready=1 → res_data=0x2C, res_index=0, res_valid at E6, done one cycle later.
2. Negative clamp, VEC_LEN=3: inputs 0x0C,0x0C,0x0C; weights 0x02,0xC0,0x7F → res_data=0x0B; the intermediate clamp to 0 is visible on mac_out.
3. Saturation: VEC_LEN=3, all inputs 0x40, all weights 0x30 → res_data=0x7F.
4. Backpressure: NUM_NEURONS=2, res_ready low for 5 cycles on neuron 0 → res_data/res_index held stable; neuron 1 not started until the handshake; stall_count=5 with PERF_COUNTER_EN.
5. Reset asserted mid-RUN of neuron 1 → immediate IDLE, mac_clear=1, busy=0, res_valid=0; a following start produces neuron 0 correctly.
6. start pulsed while busy → ignored; exactly NUM_NEURONS results and one done pulse.
